// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the RV32 core. Owns the program counter, presents
//   it combinationally as the program ROM address, and captures the ROM word into
//   the IF/ID pipeline register. Handles decode-side stall, flush (bubble with pc
//   held), and branch/jump redirects from execute.
//
// Ports
//   clk            in   1      single clock, rising edge
//   rst_n          in   1      synchronous reset, active low
//   rom_addr       out  XLEN   byte address to program ROM (= pc)
//   rom_data       in   32     instruction word for rom_addr, same cycle
//   stall          in   1      hold pc, IF/ID and fetch_cnt
//   flush          in   1      replace IF/ID with a bubble, pc held
//   redirect_valid in   1      taken branch/jump this cycle
//   redirect_pc    in   XLEN   redirect target byte address
//   if_id_pc       out  XLEN   pc of instruction held in IF/ID
//   if_id_instr    out  32     instruction held in IF/ID
//   if_id_valid    out  1      IF/ID holds a real instruction
//   misalign_err   out  1      one-cycle pulse after a redirect with target[1:0]!=0
//   fetch_cnt      out  CNT_W  count of valid instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [XLEN-1:0]  rom_addr,
  input  logic [31:0]      rom_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_plus4;

  // ROM has zero latency, so the fetch address is simply the current pc.
  assign rom_addr = pc;

  // Instructions are word aligned: the low two target bits are dropped and
  // reported through misalign_err instead of being fetched from.
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // Wraps modulo 2^XLEN naturally at the top of the address space.
  assign pc_plus4 = pc + XLEN'(4);

  // Priority per edge: reset > redirect > flush > stall > advance.
  always_ff @(posedge clk) begin
    // NOTE: all state is assigned with <= so every register samples the
    // pre-edge values of the others, independent of statement order.
    if (!rst_n) begin
      pc           <= RESET_PC;
      if_id_pc     <= '0;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else begin
      // Pulse output: cleared on every edge unless a misaligned redirect re-arms it.
      misalign_err <= 1'b0;

      if (redirect_valid) begin
        // if_id_pc is left as-is; it is meaningless while the bubble is invalid.
        pc           <= redirect_target;
        if_id_instr  <= NOP_INSTR;
        if_id_valid  <= 1'b0;
        misalign_err <= |redirect_pc[1:0];
      end else if (flush) begin
        // pc is not advanced, so the word at pc is fetched again next cycle.
        if_id_instr  <= NOP_INSTR;
        if_id_valid  <= 1'b0;
      end else if (!stall) begin
        if_id_pc     <= pc;
        if_id_instr  <= rom_data;
        if_id_valid  <= 1'b1;
        pc           <= pc_plus4;
        fetch_cnt    <= fetch_cnt + CNT_W'(1);
      end
    end
  end

endmodule
